// File: rtl/assoc_cache_ctrl_if.sv
// ---------------------------------------------------------------------------
// assoc_cache_ctrl_if
// Bundles the requester side (pipeline memory stage) and the main-memory side
// of the set-associative cache controller.
//   slave  : cache view  (takes requests, drives hit/stall/rdata and mem_*)
//   master : environment view (requester + memory, drives req_* and mem_busy/
//            mem_rdata/mem_rvalid)
// Signals:
//   req_addr/req_wdata/req_ren/req_wen : pipeline request, held while stall=1
//   rdata/hit/stall                    : response to the pipeline
//   mem_addr/mem_ren/mem_wen/mem_wdata : requests to main memory
//   mem_busy/mem_rdata/mem_rvalid      : main-memory flow control and fill data
// ---------------------------------------------------------------------------
interface assoc_cache_ctrl_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              req_ren;
    logic              req_wen;
    logic [DATA_W-1:0] rdata;
    logic              hit;
    logic              stall;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ren;
    logic              mem_wen;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_busy;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_rvalid;

    modport slave (
        input  req_addr, req_wdata, req_ren, req_wen,
        input  mem_busy, mem_rdata, mem_rvalid,
        output rdata, hit, stall,
        output mem_addr, mem_ren, mem_wen, mem_wdata
    );

    modport master (
        output req_addr, req_wdata, req_ren, req_wen,
        output mem_busy, mem_rdata, mem_rvalid,
        input  rdata, hit, stall,
        input  mem_addr, mem_ren, mem_wen, mem_wdata
    );
endinterface

// File: rtl/assoc_cache_ctrl.sv
// ---------------------------------------------------------------------------
// assoc_cache_ctrl
// N-way set-associative, write-through, write-allocate cache with a line-fill
// FSM (IDLE -> FILL -> UPDATE) and true-LRU replacement via per-way ages.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset (all outputs forced to 0 while high)
//   bus  : assoc_cache_ctrl_if.slave (pipeline request/response + memory side)
// Address layout: tag | index | word offset | bit 0 (halfword aligned).
// ---------------------------------------------------------------------------
module assoc_cache_ctrl #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int SETS   = 64,
    parameter int WAYS   = 2,
    parameter int WORDS  = 8
) (
    input  logic                clk,
    input  logic                rst,
    assoc_cache_ctrl_if.slave   bus
);
    localparam int OFF_W = $clog2(WORDS);
    localparam int IDX_W = $clog2(SETS);
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W - 1;
    localparam logic [WAY_W-1:0] OLDEST = WAY_W'(WAYS - 1);

    typedef enum logic [1:0] {IDLE, FILL, UPDATE} state_t;

    state_t state;

    // Storage. Only valid bits and ages need reset; data/tags are qualified by valid.
    logic [DATA_W-1:0] dataArr  [WAYS][SETS][WORDS];
    logic [TAG_W-1:0]  tagArr   [WAYS][SETS];
    logic [WAYS-1:0]   validArr [SETS];
    logic [WAY_W-1:0]  ageArr   [SETS][WAYS];

    // Fill context latched on a miss.
    logic [TAG_W-1:0]  fillTag;
    logic [IDX_W-1:0]  fillIdx;
    logic [WAY_W-1:0]  fillWay;
    logic [OFF_W:0]    issueCnt;   // extra bit marks "all offsets issued"
    logic [OFF_W-1:0]  retCnt;

    // Request decode.
    logic [TAG_W-1:0]  reqTag;
    logic [IDX_W-1:0]  reqIdx;
    logic [OFF_W-1:0]  reqOff;
    logic              reqAny;
    logic              reqStore;

    assign reqTag   = bus.req_addr[ADDR_W-1 -: TAG_W];
    assign reqIdx   = bus.req_addr[OFF_W+1 +: IDX_W];
    assign reqOff   = bus.req_addr[1 +: OFF_W];
    assign reqAny   = bus.req_ren | bus.req_wen;
    assign reqStore = bus.req_wen;

    // Lookup and victim selection.
    logic [WAYS-1:0]  hitVec;
    logic             anyMatch;
    logic [WAY_W-1:0] hitWay;
    logic [WAY_W-1:0] victim;

    always_comb begin
        hitVec   = '0;
        hitWay   = '0;
        victim   = '0;
        for (int w = 0; w < WAYS; w++) begin
            hitVec[w] = validArr[reqIdx][w] && (tagArr[w][reqIdx] == reqTag);
            if (hitVec[w]) hitWay = WAY_W'(w);
            if (ageArr[reqIdx][w] == OLDEST) victim = WAY_W'(w);
        end
        // Descending scan so the lowest-index invalid way wins over the LRU way.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!validArr[reqIdx][w]) victim = WAY_W'(w);
        end
        anyMatch = |hitVec;
    end

    logic fillIssuing;
    assign fillIssuing = (state == FILL) && (issueCnt < (OFF_W+1)'(WORDS));

    // Outputs are combinational (hit/stall must respond in the request cycle)
    // and all held at 0 during reset.
    logic storeWrite;

    always_comb begin
        bus.hit       = 1'b0;
        bus.stall     = 1'b0;
        bus.rdata     = '0;
        bus.mem_addr  = '0;
        bus.mem_ren   = 1'b0;
        bus.mem_wen   = 1'b0;
        bus.mem_wdata = '0;
        if (!rst) begin
            unique case (state)
                IDLE: begin
                    if (reqAny && anyMatch) begin
                        if (reqStore) begin
                            bus.mem_wen   = 1'b1;
                            bus.mem_addr  = bus.req_addr;
                            bus.mem_wdata = bus.req_wdata;
                        end
                        // A store must not complete until memory takes the write-through.
                        if (reqStore && bus.mem_busy) begin
                            bus.stall = 1'b1;
                        end else begin
                            bus.hit   = 1'b1;
                            bus.rdata = dataArr[hitWay][reqIdx][reqOff];
                        end
                    end else if (reqAny) begin
                        bus.stall = 1'b1;
                    end
                end
                FILL: begin
                    bus.stall = 1'b1;
                    if (fillIssuing) begin
                        bus.mem_ren  = 1'b1;
                        bus.mem_addr = {fillTag, fillIdx, issueCnt[OFF_W-1:0], 1'b0};
                    end
                end
                UPDATE: bus.stall = 1'b1;
                default: ;
            endcase
        end
    end

    assign storeWrite = bus.hit && reqStore;

    // LRU touch: the touched way goes to age 0, ways younger than it age by one.
    logic             touchEn;
    logic [IDX_W-1:0] touchIdx;
    logic [WAY_W-1:0] touchWay;

    always_comb begin
        touchEn  = 1'b0;
        touchIdx = reqIdx;
        touchWay = hitWay;
        if (bus.hit) begin
            touchEn = 1'b1;
        end else if (!rst && state == UPDATE) begin
            touchEn  = 1'b1;
            touchIdx = fillIdx;
            touchWay = fillWay;
        end
    end

    // Control state, valid bits and ages.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            issueCnt <= '0;
            retCnt   <= '0;
            fillTag  <= '0;
            fillIdx  <= '0;
            fillWay  <= '0;
            for (int s = 0; s < SETS; s++) begin
                validArr[s] <= '0;
                for (int w = 0; w < WAYS; w++) ageArr[s][w] <= WAY_W'(w);
            end
        end else begin
            if (touchEn) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (WAY_W'(w) == touchWay)
                        ageArr[touchIdx][w] <= '0;
                    else if (ageArr[touchIdx][w] < ageArr[touchIdx][touchWay])
                        ageArr[touchIdx][w] <= ageArr[touchIdx][w] + 1'b1;
                end
            end
            unique case (state)
                IDLE: begin
                    if (reqAny && !anyMatch) begin
                        fillTag  <= reqTag;
                        fillIdx  <= reqIdx;
                        fillWay  <= victim;
                        issueCnt <= '0;
                        retCnt   <= '0;
                        state    <= FILL;
                    end
                end
                FILL: begin
                    if (fillIssuing && !bus.mem_busy) issueCnt <= issueCnt + 1'b1;
                    if (bus.mem_rvalid) begin
                        retCnt <= retCnt + 1'b1;
                        if (retCnt == OFF_W'(WORDS - 1)) state <= UPDATE;
                    end
                end
                UPDATE: begin
                    validArr[fillIdx][fillWay] <= 1'b1;
                    state                      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Data and tag arrays; no reset needed.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == FILL && bus.mem_rvalid)
                dataArr[fillWay][fillIdx][retCnt] <= bus.mem_rdata;
            if (storeWrite)
                dataArr[hitWay][reqIdx][reqOff] <= bus.req_wdata;
            if (state == UPDATE)
                tagArr[fillWay][fillIdx] <= fillTag;
        end
    end
endmodule
